// File: rtl/axi_pkg.sv
// Shared AXI definitions for the instruction-memory read responder and the
// future write-channel responder: burst and response encodings, the
// responder state enum and the largest legal beat size.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Largest legal arsize: 8 bytes per beat on the 64-bit data bus.
    localparam logic [2:0] SIZE_MAX = 3'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address generator.
// Ports:
//   addr          current beat byte address
//   size          beat size exponent (bytes = 2^size)
//   len           captured arlen/awlen (beats - 1)
//   burst         burst type
//   next_addr     byte address of the following beat
//   illegal_burst reserved burst type, oversized beat, or WRAP with an
//                 unsupported length; such bursts step as INCR
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        illegal_burst
);

    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_lo;
    logic        wrap_ok;

    always_comb begin
        step       = 32'd1 << size;
        incr_addr  = addr + step;
        wrap_bytes = ({24'd0, len} + 32'd1) << size;
        wrap_lo    = addr & ~(wrap_bytes - 32'd1);
        wrap_ok    = wrap_len_legal(len);

        illegal_burst = (burst == BURST_RSVD) || (size > SIZE_MAX) ||
                        ((burst == BURST_WRAP) && !wrap_ok);

        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                // An illegal wrap length falls back to plain incrementing.
                if (wrap_ok && (incr_addr == wrap_lo + wrap_bytes))
                    next_addr = wrap_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_mem_axi_rd.sv
// AXI4 read-channel responder serving 64-bit instruction fetch bursts from
// an on-chip memory. One address request at a time; arlen+1 beats follow
// with rlast on the final beat, one beat per cycle under rready.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   arvalid/arready/araddr/arburst/arsize/arlen   AR channel
//   rvalid/rready/rdata/rlast/rresp               R channel (all registered)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | arready=1, waiting for an address request
// S_BURST | rvalid=1, presenting a beat; advance on each rready handshake
module instr_mem_axi_rd
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [1:0]  arburst,
    input  logic [2:0]  arsize,
    input  logic [7:0]  arlen,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic [1:0]  rresp
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 3;

    logic [63:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++)
            mem[i] = '0;
    end

    state_t      state_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  len_q;
    logic [7:0]  beats_left_q;

    logic [31:0] gen_addr;
    logic [2:0]  gen_size;
    logic [7:0]  gen_len;
    logic [1:0]  gen_burst;
    logic [31:0] gen_next;
    logic        gen_illegal;

    logic [31:0] beat_addr;
    logic [31:0] beat_off;
    logic        beat_in_range;
    logic [63:0] beat_data;
    logic [1:0]  beat_resp;

    // In IDLE the generator looks at the incoming request so its legality
    // flag covers the first beat; in BURST it steps the captured burst.
    always_comb begin
        if (state_q == S_IDLE) begin
            gen_addr  = araddr;
            gen_size  = arsize;
            gen_len   = arlen;
            gen_burst = arburst;
        end else begin
            gen_addr  = addr_q;
            gen_size  = size_q;
            gen_len   = len_q;
            gen_burst = burst_q;
        end
    end

    axi_burst_addr_gen u_addr_gen (
        .addr          (gen_addr),
        .size          (gen_size),
        .len           (gen_len),
        .burst         (gen_burst),
        .next_addr     (gen_next),
        .illegal_burst (gen_illegal)
    );

    // Single read port: the beat being loaded is either the request's first
    // address or the successor of the beat currently on the bus.
    always_comb begin
        beat_addr     = (state_q == S_IDLE) ? araddr : gen_next;
        beat_off      = beat_addr - ADDR_BASE;
        beat_in_range = ({1'b0, beat_off} < MEM_BYTES);
        beat_data     = beat_in_range ? mem[beat_off[AW+2:3]] : 64'd0;
        beat_resp     = (!beat_in_range || gen_illegal) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            arready      <= 1'b1;
            rvalid       <= 1'b0;
            rlast        <= 1'b0;
            rresp        <= RESP_OKAY;
            rdata        <= 64'd0;
            addr_q       <= 32'd0;
            size_q       <= 3'd0;
            burst_q      <= BURST_FIXED;
            len_q        <= 8'd0;
            beats_left_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arvalid && arready) begin
                        addr_q       <= araddr;
                        size_q       <= arsize;
                        burst_q      <= arburst;
                        len_q        <= arlen;
                        beats_left_q <= arlen;
                        rdata        <= beat_data;
                        rresp        <= beat_resp;
                        rlast        <= (arlen == 8'd0);
                        rvalid       <= 1'b1;
                        arready      <= 1'b0;
                        state_q      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (rvalid && rready) begin
                        if (beats_left_q == 8'd0) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            addr_q       <= gen_next;
                            beats_left_q <= beats_left_q - 8'd1;
                            rdata        <= beat_data;
                            rresp        <= beat_resp;
                            rlast        <= (beats_left_q == 8'd1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_axi_rd.sv
// Scoreboard bench for instr_mem_axi_rd: directed bursts push hand-computed
// beats into a queue; a negedge monitor pops and compares on each handshake.
module tb_instr_mem_axi_rd;

    localparam logic [31:0] B     = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [1:0]  OK    = 2'b00;
    localparam logic [1:0]  ER    = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic [1:0]  arburst = '0;
    logic [2:0]  arsize = '0;
    logic [7:0]  arlen = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [63:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;

    instr_mem_axi_rd #(.DEPTH(DEPTH), .ADDR_BASE(B), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arburst(arburst), .arsize(arsize), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rlast(rlast), .rresp(rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic        chk;
    } beat_t;

    beat_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int hs_count = 0;
    int beat_no = 0;
    bit rr_toggle = 0;
    bit idle_pending = 0;
    bit held_valid = 0;
    logic [63:0] held_data;
    logic        held_last;
    logic [1:0]  held_resp;

    function automatic logic [63:0] word_of(input int i);
        return {16'hC0DE, 16'(i), 16'h5A5A ^ 16'(i * 7), ~16'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input int word, input logic last, input logic [1:0] resp,
                            input logic chk);
        beat_t b;
        b.data = (word < 0) ? 64'd0 : word_of(word);
        b.last = last;
        b.resp = resp;
        b.chk  = chk;
        exp_q.push_back(b);
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] bt, input logic [2:0] s,
                         input logic [7:0] l);
        int n;
        @(posedge clk); #1;
        araddr = a; arburst = bt; arsize = s; arlen = l; arvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready) break;
            n++;
            if (n > 100) begin
                miscompares++;
                $display("FAIL ar_accept: arready never asserted");
                break;
            end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !arready || rvalid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL burst_timeout: %0d beats still expected", exp_q.size());
            exp_q.delete();
        end
    endtask

    // rready pattern 1,0,0,1 repeating while rr_toggle is set.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            if (rr_toggle) begin
                rready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                ph = 0;
            end
        end
    end

    // Monitor: compares each accepted beat, holds-stable checks and the
    // return to idle after a last beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (idle_pending) begin
                idle_pending = 0;
                check("idle_after_last", {62'd0, arready, rvalid}, 64'd2);
            end
            if (held_valid && rvalid)
                check("hold_stable", {rdata[60:0], held_last ^ rlast, held_resp ^ rresp},
                      {held_data[60:0], 3'b000});
            held_valid = 0;
            if (rvalid) begin
                if (rready) begin
                    hs_count++;
                    beat_no++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat%0d: unexpected beat rdata=%h rlast=%b rresp=%b",
                                 beat_no, rdata, rlast, rresp);
                    end else begin
                        e = exp_q.pop_front();
                        if (rlast !== e.last || rresp !== e.resp ||
                            (e.chk && rdata !== e.data)) begin
                            miscompares++;
                            $display("FAIL beat%0d: got rdata=%h rlast=%b rresp=%b expected rdata=%h rlast=%b rresp=%b",
                                     beat_no, rdata, rlast, rresp, e.data, e.last, e.resp);
                        end
                        if (e.last) idle_pending = 1;
                    end
                end else begin
                    held_valid = 1;
                    held_data  = rdata;
                    held_last  = rlast;
                    held_resp  = rresp;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        #1;
        for (int i = 0; i < DEPTH; i++)
            dut.mem[i] = word_of(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {rdata ^ 64'd0, 60'd0, arready, rvalid, rlast, rresp[0]},
               {64'd0, 60'd0, 4'b1000});
        check("reset_rresp", {62'd0, rresp}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // INCR, 8-byte beats, words 2..5
        exp_beat(2, 0, OK, 1); exp_beat(3, 0, OK, 1); exp_beat(4, 0, OK, 1); exp_beat(5, 1, OK, 1);
        issue(B + 32'h10, 2'b01, 3'd3, 8'd3);
        wait_done();

        // WRAP 4x8 from 0x28: 0x28,0x30,0x38,0x20
        exp_beat(5, 0, OK, 1); exp_beat(6, 0, OK, 1); exp_beat(7, 0, OK, 1); exp_beat(4, 1, OK, 1);
        issue(B + 32'h28, 2'b10, 3'd3, 8'd3);
        wait_done();

        // INCR 8 beats under rready backpressure
        hs0 = hs_count;
        for (int w = 32; w < 40; w++) exp_beat(w, w == 39, OK, 1);
        rr_toggle = 1;
        issue(B + 32'h100, 2'b01, 3'd3, 8'd7);
        wait_done();
        rr_toggle = 0;
        rready = 1'b1;
        check("handshakes_len7", 64'(hs_count - hs0), 64'd8);

        // Top of memory: last word OK, then out of range
        exp_beat(1023, 0, OK, 1); exp_beat(-1, 1, ER, 1);
        issue(B + 32'h1FF8, 2'b01, 3'd3, 8'd1);
        wait_done();

        // Just below base: out of range, then word 0
        exp_beat(-1, 0, ER, 1); exp_beat(0, 1, OK, 1);
        issue(B - 32'h8, 2'b01, 3'd3, 8'd1);
        wait_done();

        // FIXED: three beats of word 1
        exp_beat(1, 0, OK, 1); exp_beat(1, 0, OK, 1); exp_beat(1, 1, OK, 1);
        issue(B + 32'h8, 2'b00, 3'd3, 8'd2);
        wait_done();

        // Reserved burst: SLVERR on every beat, full count
        exp_beat(4, 0, ER, 0); exp_beat(5, 0, ER, 0); exp_beat(6, 1, ER, 0);
        issue(B + 32'h20, 2'b11, 3'd3, 8'd2);
        wait_done();

        // WRAP with unsupported length 3 beats
        exp_beat(5, 0, ER, 0); exp_beat(6, 0, ER, 0); exp_beat(7, 1, ER, 0);
        issue(B + 32'h28, 2'b10, 3'd3, 8'd2);
        wait_done();

        // arsize 4 is oversized for the bus
        exp_beat(0, 0, ER, 0); exp_beat(2, 1, ER, 0);
        issue(B + 32'h0, 2'b01, 3'd4, 8'd1);
        wait_done();

        // INCR 4-byte beats: 0x4,0x8,0xC,0x10
        exp_beat(0, 0, OK, 1); exp_beat(1, 0, OK, 1); exp_beat(1, 0, OK, 1); exp_beat(2, 1, OK, 1);
        issue(B + 32'h4, 2'b01, 3'd2, 8'd3);
        wait_done();

        // WRAP 4x4 from 0x38: 0x38,0x3C,0x30,0x34
        exp_beat(7, 0, OK, 1); exp_beat(7, 0, OK, 1); exp_beat(6, 0, OK, 1); exp_beat(6, 1, OK, 1);
        issue(B + 32'h38, 2'b10, 3'd2, 8'd3);
        wait_done();

        // Single-beat burst
        exp_beat(62, 1, OK, 1);
        issue(B + 32'h1F0, 2'b01, 3'd3, 8'd0);
        wait_done();

        // Reset during beat 2 of a 4-beat burst
        exp_beat(8, 0, OK, 1);
        @(posedge clk); #1;
        rready = 1'b0;
        araddr = B + 32'h40; arburst = 2'b01; arsize = 3'd3; arlen = 8'd3; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midburst_reset", {60'd0, rvalid, arready, rlast, rresp[1]}, 64'd4);
        check("midburst_reset_q", 64'(exp_q.size()), 64'd0);
        exp_beat(3, 0, OK, 1); exp_beat(4, 1, OK, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        araddr = B + 32'h18; arburst = 2'b01; arsize = 3'd3; arlen = 8'd1; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        wait_done();

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
